// File: rtl/tlc_pkg.sv
// Shared types and constants for the N-phase traffic controller.
// Light triplets are {R,Y,G} one-hot, packed three bits per phase.
package tlc_pkg;

    typedef enum logic [1:0] {
        ST_GREEN   = 2'b00,
        ST_YELLOW  = 2'b01,
        ST_ALLRED  = 2'b10,
        ST_PREEMPT = 2'b11
    } tlc_state_e;

    localparam logic [2:0] LIGHT_RED    = 3'b100;
    localparam logic [2:0] LIGHT_YELLOW = 3'b010;
    localparam logic [2:0] LIGHT_GREEN  = 3'b001;

    function automatic int light_lsb(input int phase);
        return 3 * phase;
    endfunction

endpackage

// File: rtl/tlc_phase_arbiter.sv
// Round-robin demand search: first latched call after the active phase,
// wrapping; falls back to the next phase in sequence when nothing is latched.
module tlc_phase_arbiter #(
    parameter int NUM_PHASES = 4,
    parameter int PH_W       = 2
) (
    input  logic [NUM_PHASES-1:0] dem_q,
    input  logic [PH_W-1:0]       active_phase,
    output logic [PH_W-1:0]       next_phase,
    output logic                  any_other_demand
);

    always_comb begin
        logic [PH_W-1:0] idx;
        logic            found;
        idx              = '0;
        found            = 1'b0;
        next_phase       = PH_W'((int'(active_phase) + 1) % NUM_PHASES);
        any_other_demand = 1'b0;
        // k == NUM_PHASES wraps back onto the active phase itself, searched last
        for (int k = 1; k <= NUM_PHASES; k++) begin
            idx = PH_W'((int'(active_phase) + k) % NUM_PHASES);
            if (!found && dem_q[idx]) begin
                next_phase = idx;
                found      = 1'b1;
            end
            if (k != NUM_PHASES && dem_q[idx]) begin
                any_other_demand = 1'b1;
            end
        end
    end

endmodule

// File: rtl/traffic_phase_controller.sv
// N-phase traffic-light controller: demand-actuated round-robin with
// rest-in-green, tick-enable timebase and emergency preemption.
module traffic_phase_controller
    import tlc_pkg::*;
#(
    parameter int NUM_PHASES   = 4,
    parameter int CNT_W        = 8,
    parameter int GREEN_TICKS  = 7,
    parameter int YELLOW_TICKS = 2,
    parameter int ALLRED_TICKS = 1,
    parameter int PH_W         = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    tick_en,
    input  logic [NUM_PHASES-1:0]   demand,
    input  logic                    preempt_req,
    input  logic [PH_W-1:0]         preempt_phase,
    output logic [3*NUM_PHASES-1:0] lights,
    output logic [PH_W-1:0]         active_phase,
    output logic [1:0]              fsm_state,
    output logic                    preempt_ack
);

    function automatic logic [CNT_W-1:0] dur(input int ticks);
        return (ticks <= 0) ? CNT_W'(1) : CNT_W'(ticks);
    endfunction

    tlc_state_e            state_q, state_d;
    logic [PH_W-1:0]       phase_q, phase_d;
    logic [CNT_W-1:0]      timer_q, timer_d;
    logic [NUM_PHASES-1:0] dem_q, dem_d;
    logic                  pend_q, pend_d;
    logic [PH_W-1:0]       tgt_q, tgt_d;
    logic                  req_prev_q, req_prev_d;

    logic                  req_rise, tgt_valid, capture, pend_eff;
    logic [PH_W-1:0]       tgt_eff;
    logic [PH_W-1:0]       next_phase;
    logic                  any_other_demand;
    logic                  expired, enter_serve;
    logic [NUM_PHASES-1:0] non_red;

    tlc_phase_arbiter #(
        .NUM_PHASES (NUM_PHASES),
        .PH_W       (PH_W)
    ) u_arbiter (
        .dem_q            (dem_q),
        .active_phase     (phase_q),
        .next_phase       (next_phase),
        .any_other_demand (any_other_demand)
    );

    // A request is only captured on its rising edge and held while the level stays high;
    // dropping the level cancels a pending request or ends an active preemption.
    always_comb begin
        req_rise   = preempt_req & ~req_prev_q;
        tgt_valid  = int'(preempt_phase) < NUM_PHASES;
        capture    = req_rise & tgt_valid & ~pend_q;
        pend_eff   = preempt_req & (pend_q | capture);
        tgt_eff    = capture ? preempt_phase : tgt_q;
        pend_d     = pend_eff;
        tgt_d      = tgt_eff;
        req_prev_d = preempt_req;
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        timer_d = timer_q;
        expired = (timer_q <= CNT_W'(1));
        unique case (state_q)
            ST_GREEN: begin
                if (pend_eff) begin
                    // preemption cuts green short regardless of the timebase
                    if (tgt_eff == phase_q) begin
                        state_d = ST_PREEMPT;
                    end else begin
                        state_d = ST_YELLOW;
                        timer_d = dur(YELLOW_TICKS);
                    end
                end else if (tick_en) begin
                    if (!expired) begin
                        timer_d = timer_q - CNT_W'(1);
                    end else if (any_other_demand) begin
                        state_d = ST_YELLOW;
                        timer_d = dur(YELLOW_TICKS);
                    end else begin
                        timer_d = dur(GREEN_TICKS);
                    end
                end
            end
            ST_YELLOW: begin
                if (tick_en) begin
                    if (expired) begin
                        state_d = ST_ALLRED;
                        timer_d = dur(ALLRED_TICKS);
                    end else begin
                        timer_d = timer_q - CNT_W'(1);
                    end
                end
            end
            ST_ALLRED: begin
                if (tick_en) begin
                    if (!expired) begin
                        timer_d = timer_q - CNT_W'(1);
                    end else if (pend_eff) begin
                        state_d = ST_PREEMPT;
                        phase_d = tgt_eff;
                        timer_d = dur(GREEN_TICKS);
                    end else begin
                        state_d = ST_GREEN;
                        phase_d = next_phase;
                        timer_d = dur(GREEN_TICKS);
                    end
                end
            end
            ST_PREEMPT: begin
                if (!preempt_req) begin
                    state_d = ST_YELLOW;
                    timer_d = dur(YELLOW_TICKS);
                end
            end
            default: begin
                state_d = ST_ALLRED;
                timer_d = dur(ALLRED_TICKS);
            end
        endcase

        // a call arriving on the very cycle its phase is served is absorbed by that service
        enter_serve = ((state_d == ST_GREEN)   && (state_q != ST_GREEN)) ||
                      ((state_d == ST_PREEMPT) && (state_q != ST_PREEMPT));
        dem_d = dem_q | demand;
        if (enter_serve) begin
            dem_d[phase_d] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_ALLRED;
            phase_q    <= PH_W'(NUM_PHASES - 1);
            timer_q    <= dur(ALLRED_TICKS);
            dem_q      <= '0;
            pend_q     <= 1'b0;
            tgt_q      <= '0;
            req_prev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            timer_q    <= timer_d;
            dem_q      <= dem_d;
            pend_q     <= pend_d;
            tgt_q      <= tgt_d;
            req_prev_q <= req_prev_d;
        end
    end

    always_comb begin
        lights  = '0;
        non_red = '0;
        for (int i = 0; i < NUM_PHASES; i++) begin
            lights[light_lsb(i) +: 3] = LIGHT_RED;
            if (PH_W'(i) == phase_q) begin
                unique case (state_q)
                    ST_GREEN, ST_PREEMPT: lights[light_lsb(i) +: 3] = LIGHT_GREEN;
                    ST_YELLOW:            lights[light_lsb(i) +: 3] = LIGHT_YELLOW;
                    default:              lights[light_lsb(i) +: 3] = LIGHT_RED;
                endcase
            end
            non_red[i] = (lights[light_lsb(i) +: 3] != LIGHT_RED);
        end
    end

    assign active_phase = phase_q;
    assign fsm_state    = state_q;
    assign preempt_ack  = (state_q == ST_PREEMPT);

    a_single_non_red: assert property (@(posedge clk) disable iff (!rst) $onehot0(non_red));

endmodule

// File: doc/traffic_phase_controller.md
Name: traffic_phase_controller

Overview:
Parametrised N-phase traffic-light controller. It is the successor to the fixed 4-approach controller.
- Generalised phase count and timings.
- Adds demand-actuated phase skipping, rest-in-green, a tick-enable timebase and emergency preemption.
- Sits at intersection top level. It is fed by the prescaler (tick_en), the detector/pushbutton block (demand) and the emergency receiver (preempt_*).

Parameters:
NUM_PHASES, 4, number of signal phases (2..16)
CNT_W, 8, width of phase timer
GREEN_TICKS, 7, green duration in ticks
YELLOW_TICKS, 2, yellow duration in ticks
ALLRED_TICKS, 1, all-red clearance in ticks
PH_W, $clog2(NUM_PHASES), derived phase-index width (minimum 1)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
tick_en  in  1  one-cycle timebase strobe; timer advances only when high
demand  in  NUM_PHASES  per-phase call, level or pulse
preempt_req  in  1  emergency preemption request, level
preempt_phase  in  PH_W  phase to serve during preemption
lights  out  3*NUM_PHASES  per-phase {R,Y,G} one-hot; phase i at [3i+2:3i]
active_phase  out  PH_W  phase currently green/yellow (or last cleared)
fsm_state  out  2  00 GREEN, 01 YELLOW, 10 ALLRED, 11 PREEMPT
preempt_ack  out  1  high while in PREEMPT

Behaviour:
- Encoding: red 3'b100, yellow 3'b010, green 3'b001.
  - Non-active phases are always red.
  - Active phase shows green in GREEN/PREEMPT, yellow in YELLOW, red in ALLRED.
  - lights, fsm_state and preempt_ack decode combinationally from registered state, with no extra latency.
- Reset (rst=0, async):
  - state ALLRED, active_phase=NUM_PHASES-1, timer=ALLRED_TICKS.
  - demand latch cleared, preempt target cleared.
  - All lights 3'b100, preempt_ack=0.
- Timer:
  - Loaded with the state duration on state entry.
  - On a cycle with tick_en=1: if timer==1 the transition is taken, else the timer decrements.
  - A duration parameter of 0 is treated as 1.
  - tick_en=0 freezes timer and state.
- Demand latch:
  - dem_q[i] is set on any cycle with demand[i]=1.
  - It is cleared on entry to GREEN/PREEMPT of phase i; a set on the same cycle loses to the clear.
- Transitions:
  - GREEN expiry: if any dem_q[j], j≠active, is set → YELLOW. Otherwise stay GREEN (rest-in-green) and reload the timer.
  - YELLOW expiry → ALLRED.
  - ALLRED expiry with preempt pending → PREEMPT, active_phase=target.
  - ALLRED expiry otherwise → GREEN, active_phase = first set dem_q searching active+1, active+2, … wrapping (round-robin). With no latched demand: (active+1) mod NUM_PHASES.
- Preemption:
  - preempt_req rising, with preempt_phase<NUM_PHASES, captures the target. An out-of-range phase is ignored. Target changes while pending or active are ignored.
  - If in GREEN of the target → PREEMPT next cycle, timer untouched.
  - If in GREEN of another phase → YELLOW next cycle (green truncated, independent of tick_en), then normal YELLOW and ALLRED.
  - If in YELLOW/ALLRED → complete normally, then PREEMPT.
  - PREEMPT holds the target green indefinitely with preempt_ack=1.
  - preempt_req deasserted in PREEMPT → YELLOW of the target, then normal round-robin from the target.
  - preempt_req dropped while pending (not yet in PREEMPT) cancels the request; the sequence stays normal.
- At most one phase is non-red at any time; this is a required assertion.

Decomposition:
- Package tlc_pkg holds:
  - state enum (GREEN, YELLOW, ALLRED, PREEMPT);
  - light constants LIGHT_RED/LIGHT_YELLOW/LIGHT_GREEN;
  - helper function for the light-vector index.
- Sub-module tlc_phase_arbiter: combinational round-robin search. Inputs dem_q and active_phase; outputs next_phase and any_other_demand.
- Timer, FSM and preempt logic stay in the top module.

Test Plan:
(All with GREEN_TICKS=4, YELLOW_TICKS=2, ALLRED_TICKS=1, tick_en=1 unless noted.)
- Reset, no demand: rst held 0 → lights=12'h924 (all red), fsm_state=10. After release → phase 0 green after 1 cycle, and it stays green indefinitely.
- demand=4'b1111 held → phases 0,1,2,3 green in turn: 4 green + 2 yellow + 1 all-red = 7-cycle period, 28-cycle rotation, never two non-red phases.
- Phase 0 green, 1-cycle pulse demand[2] → 0 yellow at timer expiry → all-red → phase 2 green. Phase 1 never green, dem_q[2] cleared.
- Phase 1 green 2 cycles in, preempt_req=1, preempt_phase=3 → next cycle phase 1 yellow (2 cycles), all-red (1), then phase 3 green with preempt_ack=1. Release preempt_req → phase 3 yellow for 2 cycles, ack=0.
- tick_en=1 only every 4th cycle → every state duration scales ×4. tick_en=0 held mid-yellow → state frozen.
- rst pulsed low mid-yellow between clock edges → lights all red immediately (asynchronous), fsm_state=10, preempt_ack=0.
